pwm_compare: RTL and testbench
==============================

PWM_COMPARE -- requirements
Module: pwm_compare

Interface
REQ-001 Parameter BW, default 4, SHALL give the counter width consumed by the block.
REQ-002 clk_i  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 nrst_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 nrstSync_i  input  1  SHALL be a synchronous, active-low clear, shared with the upstream counter.
REQ-005 count_i  input  BW  SHALL be the free-running up-count from the upstream counter (wraps MAX=2^BW-1 -> 0).
REQ-006 en_i  input  1  SHALL request PWM output generation.
REQ-007 duty_i  input  BW+1  SHALL carry the requested high-time in counts (0..2^BW).
REQ-008 dutyValid_i  input  1  SHALL qualify duty_i.
REQ-009 dutyReady_o  output  1  SHALL indicate that the pending-duty slot is free.
REQ-010 pwm_o  output  1  SHALL be the registered PWM waveform.
REQ-011 periodEnd_o  output  1  SHALL pulse for one cycle, one cycle after count_i==MAX.

Function
REQ-012 Handshake: duty accepted when dutyValid_i && dutyReady_o on a rising edge; duty_i SHALL be held stable by the source while valid and not ready.
REQ-013 Accepted duty SHALL be written to a pending register; dutyReady_o SHALL go low the cycle after acceptance.
REQ-014 At each cycle with count_i==MAX and pending full, pending SHALL move to active; dutyReady_o SHALL go high the following cycle.
REQ-015 Accept with pending empty in a count_i==MAX cycle SHALL bypass pending and load active directly; dutyReady_o stays high.
REQ-016 Accept with pending full is impossible (ready low); the value SHALL remain with the source.
REQ-017 Duty values above 2^BW SHALL saturate to 2^BW when stored.
REQ-018 pwm_o SHALL be registered: pwm_o <= (state is RUN or STOP) && ({1'b0,count_i} < active); latency one cycle from count_i.
REQ-019 active==0 SHALL give pwm_o constantly low; active==2^BW SHALL give pwm_o constantly high for the whole period.
REQ-020 FSM states IDLE, ARM, RUN, STOP.
REQ-021 IDLE -> ARM when en_i==1; pwm_o low in IDLE and ARM.
REQ-022 ARM -> RUN at count_i==MAX (aligns output to period start); ARM -> IDLE if en_i drops first.
REQ-023 RUN -> STOP when en_i==0; RUN SHALL otherwise persist.
REQ-024 STOP -> IDLE at count_i==MAX; STOP -> RUN when en_i returns to 1 before that, with no gap in pwm_o.
REQ-025 periodEnd_o SHALL pulse in every state, independent of en_i.

Reset
REQ-026 nrst_i low SHALL immediately force: state IDLE, pending empty, active 0, pwm_o 0, periodEnd_o 0, dutyReady_o 1.
REQ-027 nrstSync_i low SHALL produce identical values at the next rising edge; it has priority over every other input.
REQ-028 Reset mid-period or mid-handshake SHALL discard pending and active duty; no partial transfer.

Structure
REQ-029 A shared package pwm_pkg SHALL hold the FSM state encodings and the duty-saturation width constant.
REQ-030 One sub-module duty_shadow SHALL implement the pending/active registers, saturation, bypass, and dutyReady_o; pwm_compare holds the FSM and output registers.

Verification (BW=4)
REQ-031 Reset: nrst_i low while RUN with pwm_o high -> pwm_o=0, dutyReady_o=1, periodEnd_o=0 without waiting for a clock edge.
REQ-032 Alignment: duty 5 loaded in IDLE, en_i=1 at count 3 -> ARM, RUN after count 15; next period pwm_o high while counts 0..4 are sampled, low for 5..15, each one cycle late.
REQ-033 Extremes: duty 0 -> pwm_o always low; duty 16 -> always high; duty 20 -> saturated, identical to 16.
REQ-034 Back-pressure: duties 7 then 9 offered back-to-back -> 7 accepted, ready low, 9 held until the cycle after count 15; 7 active next period, 9 the one after.
REQ-035 Bypass: duty 3 accepted at count 15 with pending empty -> next period high for counts 0..2, dutyReady_o never drops.
REQ-036 Stop/resume: en_i dropped at count 8 in RUN -> PWM continues to count 15, then IDLE; a second run with en_i re-raised at count 10 -> stays RUN, uninterrupted waveform.

Source files
------------

// File: rtl/pwm_pkg.sv
// PWM compare shared definitions.
// Holds FSM encodings and the duty width extension.
package pwm_pkg;

    // Duty carries one bit more than the counter so 2^BW fits.
    localparam int DUTY_XBITS = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_compare_if.sv
// Duty handshake bundle between a duty source and pwm_compare.
// Source drives duty/valid, the compare block returns ready.
interface pwm_compare_if #(
    parameter int BW = 4
);
    import pwm_pkg::*;

    logic [BW+DUTY_XBITS-1:0] duty_i;
    logic                     dutyValid_i;
    logic                     dutyReady_o;

    modport master (
        output duty_i,
        output dutyValid_i,
        input  dutyReady_o
    );

    modport slave (
        input  duty_i,
        input  dutyValid_i,
        output dutyReady_o
    );

endinterface

// File: rtl/duty_shadow.sv
// Pending/active duty registers with saturation and bypass.
// A new duty only becomes active at a period boundary.
module duty_shadow
    import pwm_pkg::*;
#(
    parameter int BW = 4
) (
    input  logic                     clk_i,
    input  logic                     nrst_i,
    input  logic                     nrstSync_i,
    input  logic                     last_i,
    input  logic [BW+DUTY_XBITS-1:0] duty_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [BW+DUTY_XBITS-1:0] active_o
);

    localparam int DW = BW + DUTY_XBITS;
    localparam logic [DW-1:0] FULL = {1'b1, {BW{1'b0}}};

    logic [DW-1:0] pend;
    logic          full;
    logic          take;
    logic [DW-1:0] sat;

    assign ready_o = !full;
    assign take    = valid_i && !full;
    assign sat     = (duty_i > FULL) ? FULL : duty_i;

    // Capture into pending, promote at period end, or bypass when empty.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pend     <= '0;
            full     <= 1'b0;
            active_o <= '0;
        end else if (!nrstSync_i) begin
            pend     <= '0;
            full     <= 1'b0;
            active_o <= '0;
        end else if (last_i && full) begin
            active_o <= pend;
            full     <= 1'b0;
        end else if (take && last_i) begin
            active_o <= sat;
        end else if (take) begin
            pend <= sat;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/pwm_compare.sv
// PWM comparator: enable FSM plus registered pwm/period-end outputs.
// Output starts and stops on period boundaries of the upstream counter.
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int BW = 4
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic          nrstSync_i,
    input  logic [BW-1:0] count_i,
    input  logic          en_i,
    pwm_compare_if.slave  duty,
    output logic          pwm_o,
    output logic          periodEnd_o
);

    localparam int DW = BW + DUTY_XBITS;
    localparam logic [BW-1:0] MAX = '1;

    pwm_state_t    state;
    logic          last;
    logic [DW-1:0] active;

    assign last = (count_i == MAX);

    duty_shadow #(
        .BW (BW)
    ) u_shadow (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .nrstSync_i (nrstSync_i),
        .last_i     (last),
        .duty_i     (duty.duty_i),
        .valid_i    (duty.dutyValid_i),
        .ready_o    (duty.dutyReady_o),
        .active_o   (active)
    );

    // Enable FSM with the compare and period-end outputs registered alongside.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state       <= IDLE;
            pwm_o       <= 1'b0;
            periodEnd_o <= 1'b0;
        end else if (!nrstSync_i) begin
            state       <= IDLE;
            pwm_o       <= 1'b0;
            periodEnd_o <= 1'b0;
        end else begin
            periodEnd_o <= last;
            pwm_o <= ((state == RUN) || (state == STOP)) &&
                     ({1'b0, count_i} < active);
            unique case (state)
                IDLE: if (en_i) state <= ARM;
                ARM: begin
                    if (!en_i)     state <= IDLE;
                    else if (last) state <= RUN;
                end
                RUN: if (!en_i) state <= STOP;
                STOP: begin
                    if (en_i)      state <= RUN;
                    else if (last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare with BW=4.
// Scoreboard of per-cycle expectations plus a duty vector table.
module tb_pwm_compare;

    logic       clk = 1'b0;
    logic       nrst;
    logic       nrstSync;
    logic       en;
    logic [3:0] count;
    logic       pwm;
    logic       pe;
    logic [3:0] cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic  pwm;
        bit    cp;
        logic  rdy;
        bit    cr;
        logic  pe;
        string nm;
    } exp_t;

    typedef struct {
        logic [4:0] duty;
        logic [4:0] high;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[7];

    pwm_compare_if #(.BW(4)) dif ();

    pwm_compare #(
        .BW (4)
    ) dut (
        .clk_i       (clk),
        .nrst_i      (nrst),
        .nrstSync_i  (nrstSync),
        .count_i     (count),
        .en_i        (en),
        .duty        (dif),
        .pwm_o       (pwm),
        .periodEnd_o (pe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive count for one edge, queue expectations, then compare after it.
    task automatic step(input logic xp, input bit cp, input logic xr,
                        input bit cr, input string nm);
        exp_t e;
        count = cnt;
        e.pwm = xp;
        e.cp  = cp;
        e.rdy = xr;
        e.cr  = cr;
        e.pe  = nrstSync && (cnt == 4'hF);
        e.nm  = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        if (e.cp) chk({e.nm, " pwm"}, pwm, e.pwm);
        if (e.cr) chk({e.nm, " ready"}, dif.dutyReady_o, e.rdy);
        chk({e.nm, " periodEnd"}, pe, e.pe);
        cnt = nrstSync ? cnt + 4'd1 : 4'd0;
    endtask

    task automatic srst();
        nrstSync = 1'b0;
        step(1'b0, 1, 1'b1, 1, "srst");
        nrstSync = 1'b1;
    endtask

    // One full period from count 0, expecting high for counts below d.
    task automatic period(input logic [4:0] d, input string nm);
        for (int c = 0; c < 16; c++)
            step({1'b0, cnt} < d, 1, 1'b0, 0, nm);
    endtask

    // Offer duty at count 0 in IDLE, enable, ride ARM into RUN.
    task automatic load_and_arm(input logic [4:0] d, input string nm);
        dif.duty_i = d;
        dif.dutyValid_i = 1'b1;
        step(1'b0, 1, 1'b0, 1, {nm, " acc"});
        dif.dutyValid_i = 1'b0;
        en = 1'b1;
        for (int i = 1; i < 16; i++)
            step(1'b0, 1, (i == 15), 1, {nm, " arm"});
    endtask

    initial begin
        vecs[0] = '{5'd0,  5'd0};
        vecs[1] = '{5'd1,  5'd1};
        vecs[2] = '{5'd5,  5'd5};
        vecs[3] = '{5'd15, 5'd15};
        vecs[4] = '{5'd16, 5'd16};
        vecs[5] = '{5'd20, 5'd16};
        vecs[6] = '{5'd31, 5'd16};

        nrst = 1'b0;
        nrstSync = 1'b1;
        en = 1'b0;
        count = 4'd0;
        cnt = 4'd0;
        dif.duty_i = '0;
        dif.dutyValid_i = 1'b0;
        #2;
        chk("por pwm", pwm, 1'b0);
        chk("por periodEnd", pe, 1'b0);
        chk("por ready", dif.dutyReady_o, 1'b1);
        #10;
        nrst = 1'b1;

        // Duty table: each vector starts from a sync clear out of RUN.
        for (int v = 0; v < 7; v++) begin
            en = 1'b0;
            srst();
            load_and_arm(vecs[v].duty, "vec");
            period(vecs[v].high, "vec run");
        end

        // Alignment: en raised at count 3, output starts at next period.
        en = 1'b0;
        srst();
        dif.duty_i = 5'd5;
        dif.dutyValid_i = 1'b1;
        step(1'b0, 1, 1'b0, 1, "align acc");
        dif.dutyValid_i = 1'b0;
        step(1'b0, 1, 1'b0, 1, "align idle");
        step(1'b0, 1, 1'b0, 1, "align idle");
        en = 1'b1;
        for (int i = 3; i < 16; i++)
            step(1'b0, 1, (i == 15), 1, "align arm");
        period(5'd5, "align run");

        // Back-pressure: 7 accepted, 9 waits for the boundary.
        en = 1'b0;
        srst();
        en = 1'b1;
        period(5'd0, "bp arm");
        step(1'b0, 1, 1'b1, 1, "bp run0");
        step(1'b0, 1, 1'b1, 1, "bp run0");
        dif.duty_i = 5'd7;
        dif.dutyValid_i = 1'b1;
        step(1'b0, 1, 1'b0, 1, "bp acc7");
        dif.duty_i = 5'd9;
        for (int i = 3; i < 15; i++)
            step(1'b0, 1, 1'b0, 1, "bp hold9");
        step(1'b0, 1, 1'b1, 1, "bp xfer7");
        step(1'b1, 1, 1'b0, 1, "bp acc9");
        dif.dutyValid_i = 1'b0;
        for (int i = 1; i < 16; i++)
            step({1'b0, cnt} < 5'd7, 1, (i == 15), 1, "bp run7");
        for (int i = 0; i < 16; i++)
            step({1'b0, cnt} < 5'd9, 1, 1'b1, 1, "bp run9");

        // Bypass: accept 3 at count 15 with pending empty.
        en = 1'b0;
        srst();
        en = 1'b1;
        period(5'd0, "byp arm");
        for (int i = 0; i < 15; i++)
            step(1'b0, 1, 1'b1, 1, "byp run0");
        dif.duty_i = 5'd3;
        dif.dutyValid_i = 1'b1;
        step(1'b0, 1, 1'b1, 1, "byp acc3");
        dif.dutyValid_i = 1'b0;
        for (int i = 0; i < 16; i++)
            step({1'b0, cnt} < 5'd3, 1, 1'b1, 1, "byp run3");

        // Stop/resume with duty 12 so the STOP tail is visible.
        en = 1'b0;
        srst();
        load_and_arm(5'd12, "sr");
        for (int i = 0; i < 16; i++) begin
            en = (i < 8);
            step({1'b0, cnt} < 5'd12, 1, 1'b0, 0, "sr stop tail");
        end
        period(5'd0, "sr idle");
        en = 1'b1;
        period(5'd0, "sr rearm");
        for (int i = 0; i < 16; i++) begin
            en = !(i == 8 || i == 9);
            step({1'b0, cnt} < 5'd12, 1, 1'b0, 0, "sr resume");
        end
        period(5'd12, "sr resumed");

        // Async reset while RUN, pwm high and a duty pending.
        en = 1'b0;
        srst();
        load_and_arm(5'd16, "ar");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1, 1'b1, 1, "ar run16");
        dif.duty_i = 5'd8;
        dif.dutyValid_i = 1'b1;
        step(1'b1, 1, 1'b0, 1, "ar acc8");
        dif.dutyValid_i = 1'b0;
        for (int i = 6; i < 15; i++)
            step(1'b1, 1, 1'b0, 1, "ar pend8");
        nrst = 1'b0;
        #1;
        chk("ar async pwm", pwm, 1'b0);
        chk("ar async ready", dif.dutyReady_o, 1'b1);
        chk("ar async periodEnd", pe, 1'b0);
        @(posedge clk);
        #1;
        chk("ar held pwm", pwm, 1'b0);
        nrst = 1'b1;
        cnt = 4'd0;
        period(5'd0, "ar rearm");
        period(5'd0, "ar discarded");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
